// File: rtl/piso_tx_scheduler_pkg.sv
// Shared types and sizing helpers for the PISO transmit scheduler.
package piso_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    // max(1, $clog2(n)): keeps counters and indices at least one bit wide
    function automatic int unsigned width_of(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/piso_tx_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping.
module rr_arbiter
    import piso_sched_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = width_of(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [31:0] cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = {{(32-IW){1'b0}}, ptr} + i;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!any && req[cand[IW-1:0]]) begin
                any                = 1'b1;
                grant[cand[IW-1:0]] = 1'b1;
                idx                = cand[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/piso_tx_scheduler.sv
// Round-robin loads NUM_REQ word sources into one external PISO and
// frames the serial line (valid/last/source) over DATA_WIDTH shift cycles.
module piso_tx_scheduler
    import piso_sched_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned GAP_CYCLES = 0,
    localparam int unsigned SRC_W     = width_of(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         sr_din,
    output logic                          sr_din_en,
    output logic                          ser_valid,
    output logic                          ser_last,
    output logic [SRC_W-1:0]              ser_src,
    output logic                          busy
);

    localparam int unsigned BC_W = width_of(DATA_WIDTH);
    localparam int unsigned GC_W = width_of(GAP_CYCLES + 1);
    localparam logic [BC_W-1:0]  LAST_BIT = BC_W'(DATA_WIDTH - 1);
    localparam logic [SRC_W-1:0] LAST_SRC = SRC_W'(NUM_REQ - 1);

    state_t            state_q, state_d;
    logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [GC_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [SRC_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [SRC_W-1:0]  src_q, src_d;

    logic [NUM_REQ-1:0] grant;
    logic [SRC_W-1:0]   gnt_idx;
    logic               any_req;
    logic               last_bit;
    logic               load;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (SRC_W)
    ) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .grant (grant),
        .idx   (gnt_idx),
        .any   (any_req)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            rr_ptr_q  <= '0;
            src_q     <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            rr_ptr_q  <= rr_ptr_d;
            src_q     <= src_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        rr_ptr_d  = rr_ptr_q;
        src_d     = src_q;
        req_ready = '0;
        sr_din    = '0;
        sr_din_en = 1'b0;

        last_bit = (state_q == SHIFT) && (bit_cnt_q == LAST_BIT);
        // Load is suppressed under reset so no source sees an accept that is then discarded
        load = !reset && any_req &&
               ((state_q == IDLE) || (last_bit && (GAP_CYCLES == 0)));

        if (load) begin
            req_ready = grant;
            sr_din    = req_data[32'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
            sr_din_en = 1'b1;
            rr_ptr_d  = (gnt_idx == LAST_SRC) ? '0 : gnt_idx + SRC_W'(1);
            src_d     = gnt_idx;
        end

        case (state_q)
            IDLE: begin
                if (load) begin
                    state_d   = SHIFT;
                    bit_cnt_d = '0;
                end
            end
            SHIFT: begin
                if (!last_bit) begin
                    bit_cnt_d = bit_cnt_q + BC_W'(1);
                end else if (load) begin
                    bit_cnt_d = '0;
                end else if (GAP_CYCLES > 0) begin
                    state_d   = GAP;
                    gap_cnt_d = GC_W'(GAP_CYCLES - 1);
                end else begin
                    state_d = IDLE;
                end
            end
            GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - GC_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        ser_valid = (state_q == SHIFT);
        ser_last  = last_bit;
        ser_src   = src_q;
        busy      = (state_q != IDLE);
    end

endmodule

// File: tb/tb_piso_tx_scheduler.sv
// Directed bench for piso_tx_scheduler with a behavioural PISO on each instance.
module tb_piso_tx_scheduler;

    localparam int unsigned DW = 16;
    localparam int unsigned NR = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset;
    logic [NR-1:0]   req_valid;
    logic [DW-1:0]   word [NR];
    logic [NR*DW-1:0] req_data;
    assign req_data = {word[3], word[2], word[1], word[0]};

    logic [NR-1:0] rdy0, rdy2;
    logic [DW-1:0] din0, din2;
    logic          den0, den2, sv0, sv2, sl0, sl2, busy0, busy2;
    logic [1:0]    src0, src2;
    logic [DW-1:0] p0, p2;
    logic          dout0, dout2;

    int vectors = 0;
    int miscompares = 0;
    int cnt0 = 0;
    int cnt2 = 0;

    piso_tx_scheduler #(.DATA_WIDTH(DW), .NUM_REQ(NR), .GAP_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_ready(rdy0), .sr_din(din0), .sr_din_en(den0), .ser_valid(sv0),
        .ser_last(sl0), .ser_src(src0), .busy(busy0)
    );

    piso_tx_scheduler #(.DATA_WIDTH(DW), .NUM_REQ(NR), .GAP_CYCLES(2)) dut2 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_ready(rdy2), .sr_din(din2), .sr_din_en(den2), .ser_valid(sv2),
        .ser_last(sl2), .ser_src(src2), .busy(busy2)
    );

    // External PISO: load on din_en, else shift right; dout is bit 0
    always @(posedge clk) begin
        if (reset) begin
            p0 <= '0;
            p2 <= '0;
        end else begin
            p0 <= den0 ? din0 : (p0 >> 1);
            p2 <= den2 ? din2 : (p2 >> 1);
        end
    end
    assign dout0 = p0[0];
    assign dout2 = p2[0];

    // Continuous protocol checks, sampled well after inputs settle
    always @(negedge clk) begin
        #3;
        vectors++;
        if (!$onehot0(rdy0) || ((rdy0 & ~req_valid) != '0)) begin
            miscompares++;
            $display("FAIL ready_proto0: ready=%b valid=%b", rdy0, req_valid);
        end
        vectors++;
        if (!$onehot0(rdy2) || ((rdy2 & ~req_valid) != '0)) begin
            miscompares++;
            $display("FAIL ready_proto2: ready=%b valid=%b", rdy2, req_valid);
        end
        if (sv0 === 1'b1) begin
            if (sl0 === 1'b1) begin
                vectors++;
                if (cnt0 + 1 != 16) begin
                    miscompares++;
                    $display("FAIL frame_len0: got %0d expected 16", cnt0 + 1);
                end
                cnt0 = 0;
            end else cnt0++;
        end else cnt0 = 0;
        if (sv2 === 1'b1) begin
            if (sl2 === 1'b1) begin
                vectors++;
                if (cnt2 + 1 != 16) begin
                    miscompares++;
                    $display("FAIL frame_len2: got %0d expected 16", cnt2 + 1);
                end
                cnt2 = 0;
            end else cnt2++;
        end else cnt2 = 0;
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        req_valid = 4'b1111;
        @(negedge clk);
        @(negedge clk);
        #1;
        vectors++;
        if ({rdy0, den0, din0, sv0, sl0, src0, busy0} !== '0) begin
            miscompares++;
            $display("FAIL reset_outs0: got rdy=%b en=%b din=%h v=%b l=%b src=%0d busy=%b expected all 0",
                     rdy0, den0, din0, sv0, sl0, src0, busy0);
        end
        vectors++;
        if ({rdy2, den2, sv2, busy2} !== '0) begin
            miscompares++;
            $display("FAIL reset_outs2: got rdy=%b en=%b v=%b busy=%b expected all 0", rdy2, den2, sv2, busy2);
        end
        reset = 1'b0;
        req_valid = '0;
    endtask

    task automatic test_single_word();
        logic [DW-1:0] exp1;
        exp1 = 16'hA5C3;
        do_reset();
        @(negedge clk);
        word[1] = 16'hA5C3;
        req_valid = 4'b0010;
        #1;
        vectors++;
        if (rdy0 !== 4'b0010 || din0 !== 16'hA5C3 || den0 !== 1'b1) begin
            miscompares++;
            $display("FAIL single_load: got rdy=%b din=%h en=%b expected 0010 a5c3 1", rdy0, din0, den0);
        end
        @(negedge clk);
        req_valid = '0;
        for (int k = 0; k < 16; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            vectors++;
            if (sv0 !== 1'b1 || dout0 !== exp1[k[3:0]] || sl0 !== (k == 15) || src0 !== 2'd1) begin
                miscompares++;
                $display("FAIL single_bit%0d: got v=%b d=%b l=%b src=%0d expected 1 %b %b 1",
                         k, sv0, dout0, sl0, src0, exp1[k[3:0]], (k == 15));
            end
        end
        @(negedge clk);
        #1;
        vectors++;
        if (sv0 !== 1'b0 || busy0 !== 1'b0) begin
            miscompares++;
            $display("FAIL single_end: got v=%b busy=%b expected 0 0", sv0, busy0);
        end
    endtask

    task automatic test_round_robin();
        logic [NR-1:0] er;
        do_reset();
        word[0] = 16'h1234; word[1] = 16'hBEEF; word[2] = 16'h0F0F; word[3] = 16'h8001;
        @(negedge clk);
        req_valid = 4'b1111;
        #1;
        vectors++;
        if (rdy0 !== 4'b0001) begin
            miscompares++;
            $display("FAIL rr_first: got %b expected 0001", rdy0);
        end
        for (int f = 0; f < 5; f++) begin
            for (int k = 0; k < 16; k++) begin
                @(negedge clk);
                #1;
                vectors++;
                if (sv0 !== 1'b1 || src0 !== 2'(f % 4) || dout0 !== word[f % 4][k[3:0]]) begin
                    miscompares++;
                    $display("FAIL rr_f%0d_b%0d: got v=%b src=%0d d=%b expected 1 %0d %b",
                             f, k, sv0, src0, dout0, f % 4, word[f % 4][k[3:0]]);
                end
                er = (k == 15) ? 4'(1 << ((f + 1) % 4)) : 4'b0000;
                vectors++;
                if (rdy0 !== er) begin
                    miscompares++;
                    $display("FAIL rr_ready_f%0d_b%0d: got %b expected %b", f, k, rdy0, er);
                end
            end
        end
        @(negedge clk);
        req_valid = '0;
    endtask

    task automatic test_gap();
        do_reset();
        word[0] = 16'hC001; word[2] = 16'h5A0F;
        @(negedge clk);
        req_valid = 4'b0101;
        #1;
        vectors++;
        if (rdy2 !== 4'b0001) begin
            miscompares++;
            $display("FAIL gap_first: got %b expected 0001", rdy2);
        end
        @(negedge clk);
        req_valid = 4'b0100;
        for (int k = 0; k < 16; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            vectors++;
            if (sv2 !== 1'b1 || src2 !== 2'd0 || dout2 !== word[0][k[3:0]] || rdy2 !== 4'b0000) begin
                miscompares++;
                $display("FAIL gap_frame_b%0d: got v=%b src=%0d d=%b rdy=%b expected 1 0 %b 0000",
                         k, sv2, src2, dout2, rdy2, word[0][k[3:0]]);
            end
        end
        for (int g = 0; g < 2; g++) begin
            @(negedge clk);
            #1;
            vectors++;
            if (busy2 !== 1'b1 || sv2 !== 1'b0 || rdy2 !== 4'b0000) begin
                miscompares++;
                $display("FAIL gap_idle%0d: got busy=%b v=%b rdy=%b expected 1 0 0000", g, busy2, sv2, rdy2);
            end
        end
        @(negedge clk);
        #1;
        vectors++;
        if (rdy2 !== 4'b0100 || din2 !== 16'h5A0F || busy2 !== 1'b0) begin
            miscompares++;
            $display("FAIL gap_reload: got rdy=%b din=%h busy=%b expected 0100 5a0f 0", rdy2, din2, busy2);
        end
        @(negedge clk);
        req_valid = '0;
        #1;
        vectors++;
        if (sv2 !== 1'b1 || src2 !== 2'd2 || dout2 !== 1'b1) begin
            miscompares++;
            $display("FAIL gap_second: got v=%b src=%0d d=%b expected 1 2 1", sv2, src2, dout2);
        end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        word[2] = 16'h00FF; word[3] = 16'h6C39;
        @(negedge clk);
        req_valid = 4'b0100;
        #1;
        vectors++;
        if (rdy0 !== 4'b0100) begin
            miscompares++;
            $display("FAIL mid_load: got %b expected 0100", rdy0);
        end
        @(negedge clk);
        req_valid = '0;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            vectors++;
            if (dout0 !== word[2][k[3:0]]) begin
                miscompares++;
                $display("FAIL mid_bit%0d: got %b expected %b", k, dout0, word[2][k[3:0]]);
            end
        end
        reset = 1'b1;
        req_valid = 4'b1001;
        @(negedge clk);
        #1;
        vectors++;
        if ({rdy0, den0, din0, sv0, sl0, src0, busy0, dout0} !== '0) begin
            miscompares++;
            $display("FAIL mid_reset_outs: got rdy=%b en=%b din=%h v=%b l=%b src=%0d busy=%b d=%b expected all 0",
                     rdy0, den0, din0, sv0, sl0, src0, busy0, dout0);
        end
        reset = 1'b0;
        #1;
        vectors++;
        if (rdy0 !== 4'b0001) begin
            miscompares++;
            $display("FAIL mid_ptr_reset: got %b expected 0001", rdy0);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        req_valid = 4'b1000;
        #1;
        vectors++;
        if (rdy0 !== 4'b1000 || din0 !== 16'h6C39) begin
            miscompares++;
            $display("FAIL mid_src3_load: got rdy=%b din=%h expected 1000 6c39", rdy0, din0);
        end
        @(negedge clk);
        req_valid = '0;
        for (int k = 0; k < 16; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            vectors++;
            if (sv0 !== 1'b1 || src0 !== 2'd3 || dout0 !== word[3][k[3:0]] || sl0 !== (k == 15)) begin
                miscompares++;
                $display("FAIL mid_src3_b%0d: got v=%b src=%0d d=%b l=%b expected 1 3 %b %b",
                         k, sv0, src0, dout0, sl0, word[3][k[3:0]], (k == 15));
            end
        end
        @(negedge clk);
        #1;
        vectors++;
        if (sv0 !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_src3_end: got %b expected 0", sv0);
        end
    endtask

    task automatic test_withdraw_late();
        do_reset();
        word[0] = 16'h3C5A; word[1] = 16'hE817; word[2] = 16'hFFFF;
        @(negedge clk);
        req_valid = 4'b0001;
        #1;
        vectors++;
        if (rdy0 !== 4'b0001) begin
            miscompares++;
            $display("FAIL wd_load: got %b expected 0001", rdy0);
        end
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            req_valid = (k >= 3 && k <= 5) ? 4'b0100 : ((k == 15) ? 4'b0010 : 4'b0000);
            #1;
            vectors++;
            if (sv0 !== 1'b1 || dout0 !== word[0][k[3:0]]) begin
                miscompares++;
                $display("FAIL wd_bit%0d: got v=%b d=%b expected 1 %b", k, sv0, dout0, word[0][k[3:0]]);
            end
            vectors++;
            if (k == 15) begin
                if (rdy0 !== 4'b0010 || din0 !== 16'hE817 || den0 !== 1'b1) begin
                    miscompares++;
                    $display("FAIL wd_late: got rdy=%b din=%h en=%b expected 0010 e817 1", rdy0, din0, den0);
                end
            end else if (rdy0 !== 4'b0000) begin
                miscompares++;
                $display("FAIL wd_ready_b%0d: got %b expected 0000", k, rdy0);
            end
        end
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            req_valid = '0;
            #1;
            vectors++;
            if (sv0 !== 1'b1 || src0 !== 2'd1 || dout0 !== word[1][k[3:0]]) begin
                miscompares++;
                $display("FAIL wd_b2b_b%0d: got v=%b src=%0d d=%b expected 1 1 %b",
                         k, sv0, src0, dout0, word[1][k[3:0]]);
            end
        end
        @(negedge clk);
        #1;
        vectors++;
        if (sv0 !== 1'b0 || busy0 !== 1'b0) begin
            miscompares++;
            $display("FAIL wd_end: got v=%b busy=%b expected 0 0", sv0, busy0);
        end
    endtask

    initial begin
        reset = 1'b1;
        req_valid = '0;
        for (int i = 0; i < NR; i++) word[i] = '0;
        test_reset();
        test_single_word();
        test_round_robin();
        test_gap();
        test_reset_mid_frame();
        test_withdraw_late();
        @(negedge clk);
        #4;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
